// File: rtl/demux4_buf_if.sv
// Handshake bundle for the 1-to-4 distributor: one input stream and four buffered output channels.
interface demux4_buf_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;
    logic             in_vld;
    logic             in_rdy;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic [WIDTH-1:0] out_c;
    logic [WIDTH-1:0] out_d;
    logic [3:0]       out_vld;
    logic [3:0]       out_rdy;
    logic             busy;
    logic [7:0]       acc_cnt;

    modport master (
        output in_data, in_sel, in_vld, out_rdy,
        input  in_rdy, out_a, out_b, out_c, out_d, out_vld, busy, acc_cnt
    );

    modport slave (
        input  in_data, in_sel, in_vld, out_rdy,
        output in_rdy, out_a, out_b, out_c, out_d, out_vld, busy, acc_cnt
    );
endinterface

// File: rtl/demux4_buf.sv
// Registered 1-to-4 word distributor: each accepted word is steered by in_sel into a
// one-entry per-channel buffer that holds it until that channel's consumer takes it.
module demux4_buf #(
    parameter int WIDTH = 16
) (
    input logic          rclk,
    input logic          arst_l,
    demux4_buf_if.slave  bus
);
    logic [3:0][WIDTH-1:0] slot_q, slot_d;
    logic [3:0]            vld_q, vld_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  in_rdy;
    logic                  accept;

    // Readiness looks only at the addressed slot, so a full neighbour never stalls the input.
    always_comb begin
        in_rdy = ~vld_q[bus.in_sel] | bus.out_rdy[bus.in_sel];
        accept = bus.in_vld & in_rdy;
        slot_d = slot_q;
        vld_d  = vld_q & ~bus.out_rdy;
        cnt_d  = cnt_q;
        if (accept) begin
            slot_d[bus.in_sel] = bus.in_data;
            vld_d[bus.in_sel]  = 1'b1;
            cnt_d              = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            slot_q <= '0;
            vld_q  <= '0;
            cnt_q  <= '0;
        end else begin
            slot_q <= slot_d;
            vld_q  <= vld_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.in_rdy  = in_rdy;
    assign bus.out_a   = slot_q[0];
    assign bus.out_b   = slot_q[1];
    assign bus.out_c   = slot_q[2];
    assign bus.out_d   = slot_q[3];
    assign bus.out_vld = vld_q;
    assign bus.busy    = |vld_q;
    assign bus.acc_cnt = cnt_q;
endmodule

// File: tb/tb_demux4_buf.sv
// Directed bench for demux4_buf: vector table for routing/backpressure/refill, plus
// hand sequences for asynchronous reset mid-stream and accept-counter wrap.
module tb_demux4_buf;
    localparam int WIDTH = 16;

    logic rclk = 1'b0;
    logic arst_l = 1'b0;
    int   total = 0;
    int   bad = 0;

    demux4_buf_if #(.WIDTH(WIDTH)) bus ();

    demux4_buf #(.WIDTH(WIDTH)) dut (
        .rclk  (rclk),
        .arst_l(arst_l),
        .bus   (bus)
    );

    always #5 rclk = ~rclk;

    typedef struct {
        logic             vld;
        logic [1:0]       sel;
        logic [WIDTH-1:0] data;
        logic [3:0]       ordy;
        logic             exp_rdy;
        logic [3:0]       exp_vld;
        logic [7:0]       exp_cnt;
        logic [WIDTH-1:0] exp_word;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] chan_word(input logic [1:0] s);
        case (s)
            2'd0:    return bus.out_a;
            2'd1:    return bus.out_b;
            2'd2:    return bus.out_c;
            default: return bus.out_d;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [1:0] s, input logic [WIDTH-1:0] d,
                         input logic [3:0] r);
        bus.in_vld  = v;
        bus.in_sel  = s;
        bus.in_data = d;
        bus.out_rdy = r;
    endtask

    initial begin
        //        vld  sel   data      ordy   rdy  exp_vld  cnt    word
        vecs[0]  = '{1'b1, 2'd0, 16'h1111, 4'hF, 1'b1, 4'b0001, 8'd1, 16'h1111};
        vecs[1]  = '{1'b1, 2'd1, 16'h2222, 4'hF, 1'b1, 4'b0010, 8'd2, 16'h2222};
        vecs[2]  = '{1'b1, 2'd2, 16'h3333, 4'hF, 1'b1, 4'b0100, 8'd3, 16'h3333};
        vecs[3]  = '{1'b1, 2'd3, 16'h4444, 4'hF, 1'b1, 4'b1000, 8'd4, 16'h4444};
        vecs[4]  = '{1'b0, 2'd0, 16'h0000, 4'hF, 1'b1, 4'b0000, 8'd4, 16'h1111};
        vecs[5]  = '{1'b1, 2'd2, 16'hAAAA, 4'hB, 1'b1, 4'b0100, 8'd5, 16'hAAAA};
        vecs[6]  = '{1'b1, 2'd2, 16'hBBBB, 4'hB, 1'b0, 4'b0100, 8'd5, 16'hAAAA};
        vecs[7]  = '{1'b1, 2'd2, 16'hBBBB, 4'hB, 1'b0, 4'b0100, 8'd5, 16'hAAAA};
        vecs[8]  = '{1'b1, 2'd0, 16'hCCCC, 4'hB, 1'b1, 4'b0101, 8'd6, 16'hCCCC};
        vecs[9]  = '{1'b1, 2'd2, 16'hBBBB, 4'hF, 1'b1, 4'b0100, 8'd7, 16'hBBBB};
        vecs[10] = '{1'b1, 2'd1, 16'h0005, 4'h0, 1'b1, 4'b0110, 8'd8, 16'h0005};
        vecs[11] = '{1'b1, 2'd1, 16'h0006, 4'h2, 1'b1, 4'b0110, 8'd9, 16'h0006};
        vecs[12] = '{1'b0, 2'd1, 16'h0007, 4'h0, 1'b0, 4'b0110, 8'd9, 16'h0006};
        vecs[13] = '{1'b0, 2'd2, 16'h0000, 4'hF, 1'b1, 4'b0000, 8'd9, 16'hBBBB};
        vecs[14] = '{1'b0, 2'd3, 16'h0000, 4'h8, 1'b1, 4'b0000, 8'd9, 16'h4444};

        drive(1'b0, 2'd0, '0, 4'h0);
        #22;
        chk("rst_out_vld", 32'(bus.out_vld), 32'h0);
        chk("rst_acc_cnt", 32'(bus.acc_cnt), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        arst_l = 1'b1;
        #1;
        chk("rst_in_rdy", 32'(bus.in_rdy), 32'h1);
        @(posedge rclk);
        #1;

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].vld, vecs[i].sel, vecs[i].data, vecs[i].ordy);
            #1;
            chk($sformatf("v%0d_in_rdy", i), 32'(bus.in_rdy), 32'(vecs[i].exp_rdy));
            @(posedge rclk);
            #1;
            chk($sformatf("v%0d_out_vld", i), 32'(bus.out_vld), 32'(vecs[i].exp_vld));
            chk($sformatf("v%0d_acc_cnt", i), 32'(bus.acc_cnt), 32'(vecs[i].exp_cnt));
            chk($sformatf("v%0d_word", i), 32'(chan_word(vecs[i].sel)), 32'(vecs[i].exp_word));
            chk($sformatf("v%0d_busy", i), 32'(bus.busy), 32'(|vecs[i].exp_vld));
        end

        // Fill a, b, d with consumers stalled, then reset between clock edges.
        drive(1'b1, 2'd0, 16'h00A0, 4'h0);
        @(posedge rclk); #1;
        drive(1'b1, 2'd1, 16'h00B0, 4'h0);
        @(posedge rclk); #1;
        drive(1'b1, 2'd3, 16'h00D0, 4'h0);
        @(posedge rclk); #1;
        drive(1'b0, 2'd0, '0, 4'h0);
        chk("pre_rst_vld", 32'(bus.out_vld), 32'hB);
        chk("pre_rst_cnt", 32'(bus.acc_cnt), 32'd12);
        #2;
        arst_l = 1'b0;
        #1;
        chk("mid_rst_vld", 32'(bus.out_vld), 32'h0);
        chk("mid_rst_a", 32'(bus.out_a), 32'h0);
        chk("mid_rst_b", 32'(bus.out_b), 32'h0);
        chk("mid_rst_c", 32'(bus.out_c), 32'h0);
        chk("mid_rst_d", 32'(bus.out_d), 32'h0);
        chk("mid_rst_cnt", 32'(bus.acc_cnt), 32'h0);
        chk("mid_rst_busy", 32'(bus.busy), 32'h0);
        @(negedge rclk);
        arst_l = 1'b1;
        #1;
        chk("post_rst_in_rdy", 32'(bus.in_rdy), 32'h1);
        @(posedge rclk); #1;
        chk("post_rst_vld", 32'(bus.out_vld), 32'h0);

        // 256 back-to-back accepts across all channels: counter must wrap to zero.
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 2'(i % 4), 16'(i), 4'hF);
            #1;
            if (bus.in_rdy !== 1'b1) chk($sformatf("wrap_in_rdy_%0d", i), 32'(bus.in_rdy), 32'h1);
            @(posedge rclk); #1;
            if (i == 254) chk("wrap_cnt_255", 32'(bus.acc_cnt), 32'd255);
        end
        drive(1'b0, 2'd0, '0, 4'hF);
        chk("wrap_cnt_0", 32'(bus.acc_cnt), 32'd0);
        chk("wrap_last_vld", 32'(bus.out_vld), 32'h8);
        chk("wrap_last_word", 32'(bus.out_d), 32'h00FF);
        chk("wrap_busy_1", 32'(bus.busy), 32'h1);
        @(posedge rclk); #1;
        chk("wrap_busy_0", 32'(bus.busy), 32'h0);
        chk("wrap_vld_0", 32'(bus.out_vld), 32'h0);
        chk("wrap_cnt_hold", 32'(bus.acc_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
